// File: rtl/btn_sw_debounce_pkg.sv
// Shared types and defaults for the button/switch debounce slice.
// Package name is btn_sw_pkg; imported by the interface, debounce_bit and btn_sw_debounce.
package btn_sw_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHECK_HI  = 2'd1,
        STABLE_HI = 2'd2,
        CHECK_LO  = 2'd3
    } db_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_CNT_W           = 5;
    localparam int SW_W                = 8;

endpackage

// File: rtl/btn_sw_debounce_if.sv
// Raw inputs and conditioned outputs of the debounce stage.
// master = board/stimulus side, slave = debounce block.
interface btn_sw_debounce_if;
    import btn_sw_pkg::*;

    logic            btn_raw;
    logic [SW_W-1:0] sw_raw;
    logic            btn_level;
    logic            btn_press;
    logic            sel;
    logic [SW_W-1:0] sw_clean;

    modport master (
        output btn_raw, sw_raw,
        input  btn_level, btn_press, sel, sw_clean
    );

    modport slave (
        input  btn_raw, sw_raw,
        output btn_level, btn_press, sel, sw_clean
    );

endinterface

// File: rtl/btn_sw_debounce_bit.sv
// One debounced input: 2-flop synchroniser, 4-state qualify FSM, down-stream clean level.
// level is registered; level_nxt is its D input so a parent can act on the same edge.
//
// state     | meaning
// STABLE_LO | accepted level 0, watching for a 1
// CHECK_HI  | qualifying a 1, cnt = consecutive 1 samples seen
// STABLE_HI | accepted level 1, watching for a 0
// CHECK_LO  | qualifying a 0, cnt = consecutive 0 samples seen
module debounce_bit
    import btn_sw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic level_nxt
);

    localparam logic [CNT_W-1:0] TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
        $error("debounce_bit: DEBOUNCE_CYCLES must lie in 2..2**CNT_W-1");
    end

    logic             s1;
    logic             s2;
    db_state_e        state;
    db_state_e        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= STABLE_LO;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            s1    <= din;
            s2    <= s1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            STABLE_LO: begin
                if (s2) begin
                    state_nxt = CHECK_HI;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    cnt_nxt   = '0;
                end
            end
            CHECK_HI: begin
                if (!s2) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                end else if (cnt == TC) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                if (!s2) begin
                    state_nxt = CHECK_LO;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    cnt_nxt   = '0;
                end
            end
            CHECK_LO: begin
                if (s2) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                end else if (cnt == TC) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = STABLE_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

    // A pending CHECK_LO still reports the previously accepted high level.
    assign level_nxt = (state_nxt == STABLE_HI) || (state_nxt == CHECK_LO);

endmodule

// File: rtl/btn_sw_debounce.sv
// Debounces the push-button and 8 slide switches; derives press pulse and nibble select.
// Build option: define BTN_SEL_TOGGLE_EN for latched (toggle-per-press) select; default is momentary.
module btn_sw_debounce
    import btn_sw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    btn_sw_debounce_if.slave bus
);

    logic            btn_level;
    logic            btn_level_nxt;
    logic            btn_rise;
    logic            press_q;
    logic            sel_q;
    logic [SW_W-1:0] sw_level;
    logic [SW_W-1:0] sw_nxt_unused;

    debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_btn (
        .clk       (clk),
        .rst       (rst),
        .din       (bus.btn_raw),
        .level     (btn_level),
        .level_nxt (btn_level_nxt)
    );

    for (genvar i = 0; i < SW_W; i++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_sw (
            .clk       (clk),
            .rst       (rst),
            .din       (bus.sw_raw[i]),
            .level     (sw_level[i]),
            .level_nxt (sw_nxt_unused[i])
        );
    end

    // Only a LO->HI acceptance counts; CHECK_LO->STABLE_HI keeps level at 1.
    assign btn_rise = btn_level_nxt & ~btn_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            press_q <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            press_q <= btn_rise;
`ifdef BTN_SEL_TOGGLE_EN
            if (btn_rise) begin
                sel_q <= ~sel_q;
            end
`else
            sel_q   <= btn_level_nxt;
`endif
        end
    end

    assign bus.btn_level = btn_level;
    assign bus.btn_press = press_q;
    assign bus.sel       = sel_q;
    assign bus.sw_clean  = sw_level;

endmodule

// File: tb/tb_btn_sw_debounce.sv
// Directed scoreboard bench for btn_sw_debounce with DEBOUNCE_CYCLES=4 (6-edge latency).
// Expected select behaviour follows BTN_SEL_TOGGLE_EN when the bench is built with it.
module tb_btn_sw_debounce;

    localparam int DC   = 4;
    localparam int LAT  = DC + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    btn_sw_debounce_if bus ();

    btn_sw_debounce #(
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [10:0] v;
    } sb_t;

    sb_t sb_q[$];

    int n_pass  = 0;
    int n_check = 0;

    logic       exp_level = 1'b0;
    logic       exp_press = 1'b0;
    logic       exp_sel   = 1'b0;
    logic [7:0] exp_sw    = 8'h00;

    task automatic step(input string tag);
        sb_t         e;
        logic [10:0] obs;
        sb_q.push_back('{tag, {exp_level, exp_press, exp_sel, exp_sw}});
        @(posedge clk);
        #1;
        e   = sb_q.pop_front();
        obs = {bus.btn_level, bus.btn_press, bus.sel, bus.sw_clean};
        n_check++;
        assert (obs === e.v) n_pass++;
        else $error("FAIL %s observed={lvl,prs,sel,sw}=%b required=%b", e.tag, obs, e.v);
    endtask

    task automatic hold(input string tag, input int n);
        repeat (n) step(tag);
    endtask

    // Raw button already changed; expect acceptance on the LAT-th edge.
    task automatic btn_accept(input string tag, input logic new_level);
        hold(tag, LAT - 1);
        exp_level = new_level;
        if (new_level) begin
            exp_press = 1'b1;
`ifdef BTN_SEL_TOGGLE_EN
            exp_sel = ~exp_sel;
`else
            exp_sel = 1'b1;
`endif
        end else begin
`ifndef BTN_SEL_TOGGLE_EN
            exp_sel = 1'b0;
`endif
        end
        step(tag);
        exp_press = 1'b0;
    endtask

    initial begin
        bus.btn_raw = 1'b0;
        bus.sw_raw  = 8'hA5;

        // reset, then switches qualify with full latency
        hold("reset", 3);
        rst = 1'b0;
        hold("sw_init_wait", LAT - 1);
        exp_sw = 8'hA5;
        step("sw_init_edge");
        hold("sw_init_hold", 2);

        // clean press held, then release
        bus.btn_raw = 1'b1;
        btn_accept("press_step", 1'b1);
        hold("press_hold", 14);
        bus.btn_raw = 1'b0;
        btn_accept("release_step", 1'b0);
        hold("release_hold", 3);

        // bounce 1,0,1,1,0 then steady 1
        bus.btn_raw = 1'b1; step("bounce");
        bus.btn_raw = 1'b0; step("bounce");
        bus.btn_raw = 1'b1; step("bounce");
        bus.btn_raw = 1'b1; step("bounce");
        bus.btn_raw = 1'b0; step("bounce");
        bus.btn_raw = 1'b1;
        btn_accept("bounce_settle", 1'b1);
        hold("bounce_hold", 4);
        bus.btn_raw = 1'b0;
        btn_accept("bounce_release", 1'b0);
        hold("bounce_rel_hold", 2);

        // three press/release cycles
        for (int k = 0; k < 3; k++) begin
            bus.btn_raw = 1'b1;
            btn_accept("cycle_press", 1'b1);
            hold("cycle_hold", 3);
            bus.btn_raw = 1'b0;
            btn_accept("cycle_release", 1'b0);
            hold("cycle_idle", 2);
        end

        // bring sw[7] low cleanly first
        bus.sw_raw = 8'h25;
        hold("sw7_low_wait", LAT - 1);
        exp_sw = 8'h25;
        step("sw7_low_edge");
        hold("sw7_low_hold", 2);

        // 3-cycle glitch on sw[7] while the others toggle cleanly
        bus.sw_raw = 8'hDA;
        hold("sw_glitch", 3);
        bus.sw_raw = 8'h5A;
        hold("sw_glitch", LAT - 4);
        exp_sw = 8'h5A;
        step("sw_others_edge");
        hold("sw7_stays_low", 6);

        // reset at count 2 of a button qualification
        bus.btn_raw = 1'b1;
        hold("pre_rst_qual", 4);
        rst       = 1'b1;
        exp_level = 1'b0;
        exp_press = 1'b0;
        exp_sel   = 1'b0;
        exp_sw    = 8'h00;
        step("mid_qual_reset");
        rst = 1'b0;
        hold("post_rst_wait", LAT - 1);
        exp_sw = 8'h5A;
        exp_level = 1'b1;
        exp_press = 1'b1;
`ifdef BTN_SEL_TOGGLE_EN
        exp_sel = ~exp_sel;
`else
        exp_sel = 1'b1;
`endif
        step("post_rst_edge");
        exp_press = 1'b0;
        hold("post_rst_hold", 5);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
